// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address,
// and fills the IF/ID register with stall handling and redirect squash.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;
  assign pc_out   = pc;

  // Redirect beats stall: the branch in EX is older than the stalled decode op.
  // A bubble keeps the old if_id_pc/pc_plus4; only instr and valid change.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      if_id_pc       <= RESET_PC;
      if_id_pc_plus4 <= RESET_PC + 32'd4;
      if_id_instr    <= NOP_INSTR;
      if_id_valid    <= 1'b0;
      fetch_count    <= '0;
    end else if (branch_taken) begin
      pc          <= {branch_target[31:2], 2'b00};
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc             <= pc_plus4;
      if_id_pc       <= pc;
      if_id_pc_plus4 <= pc_plus4;
      if_id_instr    <= instruction;
      if_id_valid    <= 1'b1;
      fetch_count    <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage, plus a PC-wrap sequence on a
// second instance built with RESET_PC = 32'hFFFF_FFFC.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [31:0] branch_target, instruction;
  logic [31:0] pc_out, if_id_pc, if_id_pc_plus4, if_id_instr, fetch_count;
  logic        if_id_valid;

  logic        w_reset;
  logic [31:0] w_instruction;
  logic [31:0] w_pc_out, w_if_id_pc, w_if_id_pc_plus4, w_if_id_instr, w_fetch_count;
  logic        w_if_id_valid;

  logic [31:0] mem [32];

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .instruction(instruction), .pc_out(pc_out),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_wrap (
    .clk(clk), .reset(w_reset), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .instruction(w_instruction), .pc_out(w_pc_out),
    .if_id_pc(w_if_id_pc), .if_id_pc_plus4(w_if_id_pc_plus4), .if_id_instr(w_if_id_instr),
    .if_id_valid(w_if_id_valid), .fetch_count(w_fetch_count)
  );

  // Instruction memory: word-indexed by pc_out[6:2], returns 0 while in reset.
  assign instruction = reset ? 32'h0 : mem[pc_out[6:2]];

  // Memory image: addi x1,x0,i at words 0..7, NOPs beyond.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] idx;
    idx = {27'h0, a[6:2]};
    return (idx < 8) ? (32'h0000_0093 | (idx << 20)) : NOP;
  endfunction

  typedef struct {
    logic        rst, stl, bt;
    logic [31:0] tgt;
    logic [31:0] pc, ipc, ipc4, instr;
    logic        v;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic stl, input logic bt,
                              input logic [31:0] tgt, input logic [31:0] pc,
                              input logic [31:0] ipc, input logic [31:0] instr,
                              input logic v, input logic [31:0] cnt);
    vec_t r;
    r.rst = rst; r.stl = stl; r.bt = bt; r.tgt = tgt;
    r.pc = pc; r.ipc = ipc; r.ipc4 = ipc + 32'd4; r.instr = instr; r.v = v; r.cnt = cnt;
    vecs.push_back(r);
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = word_at(32'(i) << 2);

    // Segment A: reset, then free-run through the 8 ALU ops.
    add(1, 0, 0, 0, 0, 0, NOP, 0, 0);
    add(1, 0, 0, 0, 0, 0, NOP, 0, 0);
    for (int k = 1; k <= 8; k++)
      add(0, 0, 0, 0, 32'(4 * k), 32'(4 * (k - 1)), word_at(32'(4 * (k - 1))), 1, 32'(k));

    // Segment B: stall, redirect with unaligned target, stall+redirect, self-redirect.
    add(1, 0, 0, 0, 0, 0, NOP, 0, 0);
    add(0, 0, 0, 0, 32'h4, 32'h0, word_at(32'h0), 1, 1);
    add(0, 0, 0, 0, 32'h8, 32'h4, word_at(32'h4), 1, 2);
    for (int k = 0; k < 3; k++)
      add(0, 1, 0, 0, 32'h8, 32'h4, word_at(32'h4), 1, 2);
    add(0, 0, 0, 0,        32'h0C, 32'h08, word_at(32'h08), 1, 3);
    add(0, 0, 0, 0,        32'h10, 32'h0C, word_at(32'h0C), 1, 4);
    add(0, 0, 1, 32'h13,   32'h10, 32'h0C, NOP,             0, 4);
    add(0, 0, 0, 0,        32'h14, 32'h10, word_at(32'h10), 1, 5);
    add(0, 1, 1, 32'h40,   32'h40, 32'h10, NOP,             0, 5);
    add(0, 0, 0, 0,        32'h44, 32'h40, word_at(32'h40), 1, 6);
    add(0, 0, 1, 32'h44,   32'h44, 32'h40, NOP,             0, 6);
    add(0, 0, 0, 0,        32'h48, 32'h44, word_at(32'h44), 1, 7);

    // Segment C: run to pc 0x1C / count 7, then reset while stall and redirect are high.
    add(1, 0, 0, 0, 0, 0, NOP, 0, 0);
    for (int k = 1; k <= 7; k++)
      add(0, 0, 0, 0, 32'(4 * k), 32'(4 * (k - 1)), word_at(32'(4 * (k - 1))), 1, 32'(k));
    add(1, 1, 1, 32'h80, 0, 0, NOP, 0, 0);

    w_reset = 1'b1;
    w_instruction = 32'h0;

    for (int r = 0; r < vecs.size(); r++) begin
      reset = vecs[r].rst;
      stall = vecs[r].stl;
      branch_taken = vecs[r].bt;
      branch_target = vecs[r].tgt;
      @(posedge clk);
      #1;
      chk("pc_out",         r, pc_out,           vecs[r].pc);
      chk("if_id_pc",       r, if_id_pc,         vecs[r].ipc);
      chk("if_id_pc_plus4", r, if_id_pc_plus4,   vecs[r].ipc4);
      chk("if_id_instr",    r, if_id_instr,      vecs[r].instr);
      chk("if_id_valid",    r, {31'h0, if_id_valid}, {31'h0, vecs[r].v});
      chk("fetch_count",    r, fetch_count,      vecs[r].cnt);
    end

    // PC wrap: reset value 0xFFFF_FFFC, one normal edge wraps to 0.
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    w_reset = 1'b1;
    @(posedge clk); #1;
    chk("wrap_reset_pc",    100, w_pc_out,         32'hFFFF_FFFC);
    chk("wrap_reset_pc4",   100, w_if_id_pc_plus4, 32'h0000_0000);
    chk("wrap_reset_valid", 100, {31'h0, w_if_id_valid}, 32'h0);
    w_reset = 1'b0;
    w_instruction = 32'h00A0_0093;
    @(posedge clk); #1;
    chk("wrap_pc_out",  101, w_pc_out,         32'h0000_0000);
    chk("wrap_ifpc",    101, w_if_id_pc,       32'hFFFF_FFFC);
    chk("wrap_ifpc4",   101, w_if_id_pc_plus4, 32'h0000_0000);
    chk("wrap_instr",   101, w_if_id_instr,    32'h00A0_0093);
    chk("wrap_valid",   101, {31'h0, w_if_id_valid}, 32'h1);
    chk("wrap_count",   101, w_fetch_count,    32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
